fpga_cfg_loader: RTL and testbench

Configuration loader sitting directly upstream of `fpga_core`. It accepts configuration bytes from a host over a valid/ready stream, serialises them LSB-first, and drives either the CLB scan chain or the connection scan chain. It generates `scan_clk`, the scan enables and scan data for the core. It holds the core's logic reset asserted while a load is in progress.

---
 rtl/fpga_cfg_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_loader.sv
// ---------------------------------------------------------------------------
// fpga_cfg_loader
//
// Purpose:
//   Takes configuration bytes from a host over a valid/ready stream,
//   serialises them LSB-first and shifts them into either the CLB scan chain
//   or the connection scan chain of fpga_core. It generates scan_clk at
//   clk/2, drives the scan enables and scan data, and holds the core's logic
//   reset asserted while a load is in progress.
//
// Parameters:
//   CLB_CHAIN_LEN   bits in the CLB scan chain
//   CONN_CHAIN_LEN  bits in the connection scan chain
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-low reset
//   cfg_start      one-cycle load request (honoured only when idle)
//   cfg_sel        chain select sampled with cfg_start (0 = CLB, 1 = conn)
//   cfg_data       configuration byte, bit 0 shifted first
//   cfg_valid      cfg_data valid
//   cfg_ready      loader accepts a byte this cycle
//   cfg_busy       load in progress
//   cfg_done       one-cycle pulse when the selected chain is fully loaded
//   scan_clk       generated scan clock (registered)
//   clb_scan_in/clb_scan_en    CLB chain data / enable
//   conn_scan_in/conn_scan_en  connection chain data / enable
//   clb_scan_out/conn_scan_out chain tail bits (readback only)
//   core_reset     active-high logic reset for the core
//   rb_data/rb_valid           readback byte stream (only with the macro)
//
// Build option:
//   Define FPGA_CFG_READBACK_EN to add the readback path (rb_data, rb_valid).
// ---------------------------------------------------------------------------
module fpga_cfg_loader #(
    parameter int CLB_CHAIN_LEN  = 1024,
    parameter int CONN_CHAIN_LEN = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    input  logic       cfg_sel,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       scan_clk,
    output logic       clb_scan_in,
    output logic       clb_scan_en,
    output logic       conn_scan_in,
    output logic       conn_scan_en,
    input  logic       clb_scan_out,
    input  logic       conn_scan_out,
`ifdef FPGA_CFG_READBACK_EN
    output logic [7:0] rb_data,
    output logic       rb_valid,
`endif
    output logic       core_reset
);

    localparam int MAX_LEN = (CLB_CHAIN_LEN > CONN_CHAIN_LEN) ? CLB_CHAIN_LEN : CONN_CHAIN_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          lastBit;
    logic          scanBit;

    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic sclk_q, sclk_d;
    logic clbIn_q, clbIn_d;
    logic clbEn_q, clbEn_d;
    logic connIn_q, connIn_d;
    logic connEn_q, connEn_d;
    logic coreRst_q, coreRst_d;

`ifdef FPGA_CFG_READBACK_EN
    logic [7:0] rbShift_q, rbShift_d;
    logic [7:0] rbData_q, rbData_d;
    logic       rbValid_q, rbValid_d;
    logic [7:0] rbTmp;
    logic       rbTail;
`else
    // Tail bits only feed the readback path, which is not built here.
    logic unusedTails;
    assign unusedTails = clb_scan_out ^ conn_scan_out;
`endif

    // Next-state logic. Every output is derived from the next state so that
    // the registered outputs line up with the state they describe.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        lastBit = (cnt_q + CW'(1)) == len_q;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    sel_d   = cfg_sel;
                    len_d   = cfg_sel ? CW'(CONN_CHAIN_LEN) : CW'(CLB_CHAIN_LEN);
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cfg_valid && ready_q) begin
                    shift_d = cfg_data;
                    idx_d   = '0;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: state_d = SHIFT_HI;
            SHIFT_HI: begin
                cnt_d   = cnt_q + CW'(1);
                idx_d   = idx_q + 3'd1;
                shift_d = shift_q >> 1;
                // A short final byte ends on the length match, so its unused
                // high bits are simply never shifted out.
                if (lastBit)
                    state_d = DONE;
                else if (idx_q == 3'd7)
                    state_d = LOAD;
                else
                    state_d = SHIFT_LO;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Data changes only on entry to SHIFT_LO and is held otherwise, so it
        // is stable a full cycle either side of each scan_clk rise.
        if (state_d == SHIFT_LO)
            scanBit = shift_d[0];
        else if (state_d == SHIFT_HI || state_d == LOAD)
            scanBit = clbIn_q | connIn_q;
        else
            scanBit = 1'b0;

        ready_d   = (state_d == LOAD);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        sclk_d    = (state_d == SHIFT_HI);
        coreRst_d = (state_d != IDLE);
        clbEn_d   = (state_d inside {LOAD, SHIFT_LO, SHIFT_HI}) && !sel_d;
        connEn_d  = (state_d inside {LOAD, SHIFT_LO, SHIFT_HI}) &&  sel_d;
        clbIn_d   = scanBit && !sel_d;
        connIn_d  = scanBit &&  sel_d;
    end

`ifdef FPGA_CFG_READBACK_EN
    // Readback: the selected tail bit is captured at its byte position in each
    // SHIFT_HI cycle; a byte is emitted after bit 7 or after the final bit,
    // and the staging register is cleared so a short byte is zero-padded.
    always_comb begin
        rbShift_d = rbShift_q;
        rbData_d  = rbData_q;
        rbValid_d = 1'b0;
        rbTail    = sel_q ? conn_scan_out : clb_scan_out;
        rbTmp     = rbShift_q;
        if (state_q == IDLE && cfg_start) begin
            rbShift_d = '0;
        end else if (state_q == SHIFT_HI) begin
            rbTmp[idx_q] = rbTail;
            if (lastBit || idx_q == 3'd7) begin
                rbData_d  = rbTmp;
                rbValid_d = 1'b1;
                rbShift_d = '0;
            end else begin
                rbShift_d = rbTmp;
            end
        end
    end
`endif

    // State and output registers; reset returns everything to idle with the
    // core held in reset, which also aborts any load in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            clbIn_q   <= 1'b0;
            clbEn_q   <= 1'b0;
            connIn_q  <= 1'b0;
            connEn_q  <= 1'b0;
            coreRst_q <= 1'b1;
`ifdef FPGA_CFG_READBACK_EN
            rbShift_q <= '0;
            rbData_q  <= '0;
            rbValid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            clbIn_q   <= clbIn_d;
            clbEn_q   <= clbEn_d;
            connIn_q  <= connIn_d;
            connEn_q  <= connEn_d;
            coreRst_q <= coreRst_d;
`ifdef FPGA_CFG_READBACK_EN
            rbShift_q <= rbShift_d;
            rbData_q  <= rbData_d;
            rbValid_q <= rbValid_d;
`endif
        end
    end

    assign cfg_ready    = ready_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign scan_clk     = sclk_q;
    assign clb_scan_in  = clbIn_q;
    assign clb_scan_en  = clbEn_q;
    assign conn_scan_in = connIn_q;
    assign conn_scan_en = connEn_q;
    assign core_reset   = coreRst_q;
`ifdef FPGA_CFG_READBACK_EN
    assign rb_data      = rbData_q;
    assign rb_valid     = rbValid_q;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_fpga_cfg_loader
//
// Self-checking bench for fpga_cfg_loader with short chains (CLB = 12 bits,
// connection = 8 bits). Expected bit streams, handshake counts and done
// timing come from a simple model of the load rules: bit i of the chain is
// bit (i mod 8) of byte (i / 8), ceil(L/8) bytes are taken, and done appears
// stall + ceil(L/8) + 2L cycles after the start cycle.
// ---------------------------------------------------------------------------
module tb_fpga_cfg_loader;

    localparam int CLB_LEN  = 12;
    localparam int CONN_LEN = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_start;
    logic       cfg_sel;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_busy;
    logic       cfg_done;
    logic       scan_clk;
    logic       clb_scan_in;
    logic       clb_scan_en;
    logic       conn_scan_in;
    logic       conn_scan_en;
    logic       clb_scan_out;
    logic       conn_scan_out;
    logic       core_reset;

    int checks   = 0;
    int failures = 0;

`ifdef FPGA_CFG_READBACK_EN
    logic [7:0]  rb_data;
    logic        rb_valid;
    logic [11:0] chainModel;
    logic [7:0]  rbQ[$];

    // A 12-bit CLB chain preloaded while reset is low; it shifts on the clk
    // edge that ends each scan_clk-high cycle, so the loader sees the old tail.
    always @(posedge clk) begin
        if (!reset)
            chainModel <= 12'h3C5;
        else if (scan_clk && clb_scan_en)
            chainModel <= {clb_scan_in, chainModel[11:1]};
    end
    assign clb_scan_out = chainModel[0];
`else
    assign clb_scan_out = 1'b0;
`endif
    assign conn_scan_out = 1'b0;

    fpga_cfg_loader #(
        .CLB_CHAIN_LEN (CLB_LEN),
        .CONN_CHAIN_LEN(CONN_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .scan_clk     (scan_clk),
        .clb_scan_in  (clb_scan_in),
        .clb_scan_en  (clb_scan_en),
        .conn_scan_in (conn_scan_in),
        .conn_scan_en (conn_scan_en),
        .clb_scan_out (clb_scan_out),
        .conn_scan_out(conn_scan_out),
`ifdef FPGA_CFG_READBACK_EN
        .rb_data      (rb_data),
        .rb_valid     (rb_valid),
`endif
        .core_reset   (core_reset)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports a failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs packed as {scan_clk, clb_in, clb_en, conn_in, conn_en, ready, busy, done, core_reset}.
    function automatic logic [31:0] outVec();
        return {23'd0, scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
                cfg_ready, cfg_busy, cfg_done, core_reset};
    endfunction

    // Runs one complete load and checks it against the model. The first byte
    // is offered from cycle 'stall' on (cycle 1 = first cycle after start is
    // sampled); glitchCyc > 0 pulses cfg_start with the opposite select then.
    task automatic applyStimulus(input string tag, input logic sel, input logic [7:0] b0,
                                 input logic [7:0] b1, input int stall, input int glitchCyc);
        logic [7:0]  bytes[2];
        logic [31:0] expBits;
        logic [31:0] got;
        int          len, nb, cyc, bi, hs, doneCyc, nBits;
        bit          doneSeen, otherSeen, busyDrop, readyMiss, hsNow;

        bytes[0] = b0;
        bytes[1] = b1;
        len      = sel ? CONN_LEN : CLB_LEN;
        nb       = (len + 7) / 8;
        expBits  = '0;
        for (int i = 0; i < len; i++) expBits[i] = bytes[i / 8][i % 8];

        got = '0; hs = 0; nBits = 0; doneCyc = -1;
        doneSeen = 0; otherSeen = 0; busyDrop = 0; readyMiss = 0;

        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_sel   = sel;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cyc       = 1;
        bi        = 0;
        cfg_valid = (cyc >= stall);
        cfg_data  = bytes[0];

        while (!doneSeen && cyc < 200) begin
            @(negedge clk);
            hsNow = cfg_valid && cfg_ready;
            if (hsNow) hs++;
            if (cyc < stall && !cfg_ready) readyMiss = 1;
            if (scan_clk && nBits < 32) begin
                got[nBits] = sel ? conn_scan_in : clb_scan_in;
                nBits++;
            end
            if (sel ? (clb_scan_en || clb_scan_in) : (conn_scan_en || conn_scan_in)) otherSeen = 1;
            if (!cfg_busy || !core_reset) busyDrop = 1;
`ifdef FPGA_CFG_READBACK_EN
            if (rb_valid) rbQ.push_back(rb_data);
`endif
            if (cfg_done) begin
                doneSeen = 1;
                doneCyc  = cyc;
            end else begin
                @(posedge clk); #1;
                if (hsNow) bi++;
                cyc++;
                cfg_start = (cyc == glitchCyc);
                cfg_sel   = (cyc == glitchCyc) ? ~sel : sel;
                cfg_valid = (cyc >= stall) && (bi < nb);
                cfg_data  = bytes[(bi < nb) ? bi : 0];
            end
        end

        checkOutput({tag, "_done_seen"}, 32'(doneSeen), 32'd1);
        checkOutput({tag, "_done_cycle"}, 32'(doneCyc), 32'(stall + nb + 2 * len));
        checkOutput({tag, "_handshakes"}, 32'(hs), 32'(nb));
        checkOutput({tag, "_bit_count"}, 32'(nBits), 32'(len));
        checkOutput({tag, "_bits"}, got, expBits);
        checkOutput({tag, "_other_chain_quiet"}, 32'(otherSeen), 32'd0);
        checkOutput({tag, "_busy_and_core_reset_held"}, 32'(busyDrop), 32'd0);
        if (stall > 1) checkOutput({tag, "_ready_while_waiting"}, 32'(readyMiss), 32'd0);

        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_sel   = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idle_after_done"}, outVec(), 32'h0);
    endtask

    initial begin
        logic [7:0] r0, r1;
        logic       rs;
        int         hi;

        $display("[TB] fpga_cfg_loader bench start");
        reset     = 1'b0;
        cfg_start = 1'b0;
        cfg_sel   = 1'b0;
        cfg_data  = 8'h00;
        cfg_valid = 1'b0;

        // Reset held low for three cycles: everything idle, core in reset.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_values", outVec(), 32'h1);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("core_reset_before_release_edge", 32'(core_reset), 32'd1);
        @(negedge clk);
        checkOutput("core_reset_after_release", 32'(core_reset), 32'd0);

        // Directed CLB load: 0xA5, 0x0F -> 1,0,1,0,0,1,0,1,1,1,1,1, done at 27.
        applyStimulus("clb_a5_0f", 1'b0, 8'hA5, 8'h0F, 1, 0);
`ifdef FPGA_CFG_READBACK_EN
        checkOutput("rb_count", 32'(rbQ.size()), 32'd2);
        if (rbQ.size() == 2) begin
            checkOutput("rb_byte0", 32'(rbQ[0]), 32'hC5);
            checkOutput("rb_byte1", 32'(rbQ[1]), 32'h03);
        end
`endif

        // Connection load, byte 0x81 offered five cycles after start.
        applyStimulus("conn_81_stall", 1'b1, 8'h81, 8'h00, 5, 0);

        // Start with the other select mid-load must be ignored.
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        applyStimulus("start_while_busy", 1'b0, r0, r1, 1, 6);

        // Reset during the scan_clk-high cycle of bit 5 aborts the load.
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_sel   = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
        hi = 0;
        for (int c = 0; c < 60 && hi < 6; c++) begin
            @(negedge clk);
            if (scan_clk) hi++;
        end
        checkOutput("midload_reached_bit5", 32'(hi), 32'd6);
        reset = 1'b0;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        checkOutput("midload_reset_values", outVec(), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midload_core_reset_released", 32'(core_reset), 32'd0);
        applyStimulus("after_abort", 1'b0, 8'h3C, 8'h09, 1, 0);

        // Randomised loads on both chains with random initial stalls.
        for (int n = 0; n < 6; n++) begin
            rs = 1'($urandom_range(0, 1));
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            applyStimulus($sformatf("random%0d", n), rs, r0, r1, int'($urandom_range(1, 4)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
